// File: rtl/urv_writeback_nb_pkg.sv
// Shared definitions for the non-blocking writeback stage: load/store width codes,
// result source selects and the load-queue entry layout.
package urv_writeback_nb_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
  localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
  localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;

  localparam int LQ_RD_W  = 5;
  localparam int LQ_FUN_W = 3;
  localparam int LQ_OFF_W = 2;

  typedef struct packed {
    logic [LQ_RD_W-1:0]  rd;
    logic [LQ_FUN_W-1:0] fun;
    logic [LQ_OFF_W-1:0] off;
  } lq_entry_t;

endpackage

// File: rtl/urv_writeback_nb_load_align.sv
// urv_load_align: picks the addressed byte/half/word out of returned load data
// and sign- or zero-extends it according to the load width code.
module urv_load_align
  import urv_writeback_nb_pkg::*;
(
  input  logic [2:0]  fun_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = data_i[{off_i, 3'b000} +: 8];
    w_half  = off_i[1] ? data_i[31:16] : data_i[15:0];
    value_o = data_i;
    case (fun_i)
      LDST_B:  value_o = {{24{w_byte[7]}}, w_byte};
      LDST_BU: value_o = {24'b0, w_byte};
      LDST_H:  value_o = {{16{w_half[15]}}, w_half};
      LDST_HU: value_o = {16'b0, w_half};
      default: value_o = data_i;
    endcase
  end

endmodule

// File: rtl/urv_writeback_nb.sv
// Non-blocking writeback: in-order load queue, store counter, pending-register mask
// and a shared register-file write port. Optional URV_WB_MISALIGN_CHECK_EN rejects misaligned loads.
module urv_writeback_nb
  import urv_writeback_nb_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int ST_MAX   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic [31:0] w_pending_o,
  output logic        w_idle_o,
  output logic        w_misaligned_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int SW = $clog2(ST_MAX + 1);

  lq_entry_t        r_lq [LQ_DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_st_count;
  logic [31:0]      r_pending;

  lq_entry_t        w_head;
  logic [31:0]      w_load_value, w_nl_value;
  logic             w_pop, w_push, w_load_we, w_is_load, w_is_nl, w_misalign;
  logic             w_load_stall, w_nl_stall, w_st_inc, w_st_dec, w_st_stall, w_st_accept;
  logic             w_full, w_rd_pending;
  logic             w_unused_addr;

  assign w_unused_addr = ^x_dm_addr_i[31:2];
  assign w_head        = r_lq[r_rptr];
  assign w_full        = (r_count == CW'(LQ_DEPTH));
  assign w_pop         = dm_load_done_i && (r_count != '0);
  assign w_load_we     = w_pop && (w_head.rd != 5'd0);
  assign w_rd_pending  = r_pending[x_rd_i];
  assign w_is_load     = x_valid_i && x_load_i;
  assign w_is_nl       = x_valid_i && !x_load_i && !x_store_i && x_rd_write_i;

`ifdef URV_WB_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_is_load) begin
      case (x_fun_i)
        LDST_H, LDST_HU: w_misalign = x_dm_addr_i[0];
        LDST_W:          w_misalign = |x_dm_addr_i[1:0];
        default:         w_misalign = 1'b0;
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Hazard check uses pre-pop pending state, so a same-cycle pop of the same rd still stalls.
  assign w_load_stall = w_is_load && !w_misalign && ((w_full && !w_pop) || w_rd_pending);
  assign w_push       = w_is_load && !w_misalign && !w_load_stall;
  assign w_nl_stall   = w_is_nl && (w_load_we || w_rd_pending);

  assign w_st_inc     = x_valid_i && x_store_i;
  assign w_st_dec     = dm_store_done_i && (r_st_count != '0);
  assign w_st_stall   = w_st_inc && (r_st_count == SW'(ST_MAX)) && !dm_store_done_i;
  assign w_st_accept  = w_st_inc && !w_st_stall;

  assign w_stall_req_o  = w_load_stall || w_nl_stall || w_st_stall;
  assign w_misaligned_o = w_misalign;
  assign w_pending_o    = r_pending;
  assign w_idle_o       = (r_count == '0) && (r_st_count == '0);

  urv_load_align u_align (
    .fun_i   (w_head.fun),
    .off_i   (w_head.off),
    .data_i  (dm_data_l_i),
    .value_o (w_load_value)
  );

  always_comb begin
    case (x_rd_source_i)
      RD_SOURCE_SHIFTER:  w_nl_value = x_shifter_rd_value_i;
      RD_SOURCE_MULTIPLY: w_nl_value = x_multiply_rd_value_i;
      default:            w_nl_value = x_rd_value_i;
    endcase
  end

  always_comb begin
    rf_rd_o       = x_rd_i;
    rf_rd_value_o = w_nl_value;
    rf_rd_write_o = w_is_nl && !w_nl_stall;
    if (w_load_we) begin
      rf_rd_o       = w_head.rd;
      rf_rd_value_o = w_load_value;
      rf_rd_write_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_lq[r_wptr] <= '{rd: x_rd_i, fun: x_fun_i, off: x_dm_addr_i[1:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_st_count <= '0;
      r_pending  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(LQ_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(LQ_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_st_accept && !w_st_dec)      r_st_count <= r_st_count + SW'(1);
      else if (w_st_dec && !w_st_accept) r_st_count <= r_st_count - SW'(1);
      r_pending <= (r_pending & ~(w_pop ? (32'd1 << w_head.rd) : 32'd0))
                 | ((w_push && x_rd_i != 5'd0) ? (32'd1 << x_rd_i) : 32'd0);
    end
  end

endmodule
